key_entry_buffer: RTL
=====================

// Module: key_entry_buffer
// PURPOSE
//  Sits between the matrix-keypad decoder (KEY_Value/Value_en) and the 8-digit tube display controller.
//  Turns decoded key events into an editable multi-digit entry: digit keys shift in, command keys edit or commit.
//  Drives the live edit buffer and blanking mask to the display, and hands the committed value downstream.
// PARAMETERS
//  N_DIGITS     8         digit positions in the buffer (1..8)
//  TIMEOUT_CYC  50000000  idle clocks without a key before auto-clear (0 = disabled)
// PORTS
//  CLK          in   1            system clock, rising edge
//  nRST         in   1            asynchronous active-low reset
//  KEY_Value    in   4            decoded key code, valid while Value_en high
//  Value_en     in   1            key-valid level from the keypad decoder; may stay high for many cycles
//  DIGITS       out  4*N_DIGITS   edit buffer; digit 0 = [3:0] = rightmost = most recent key
//  DIGIT_MASK   out  N_DIGITS     1 = position holds an entered digit (display blanks 0 positions)
//  VALUE        out  4*N_DIGITS   last committed entry, BCD, same layout as DIGITS
//  VALUE_VALID  out  1            one-cycle pulse when VALUE is updated
//  FULL         out  1            level; all N_DIGITS positions occupied
//  ERR          out  1            one-cycle pulse on a rejected key (overflow, enter on empty)
// BEHAVIOUR
//  Reset: DIGITS=0, DIGIT_MASK=0, VALUE=0, VALUE_VALID=0, FULL=0, ERR=0, state EMPTY, count=0, timer=0.
//  Event detect: en_d <= Value_en; key event = Value_en & ~en_d, sampled with KEY_Value in the same cycle.
//   Holding Value_en high yields exactly one event. en_d resets to 1, so a key held through reset gives no event.
//  Latency: all outputs change on the edge that samples the event (visible 1 cycle after the event cycle).
//  Key codes: 0x0-0x9 digit; 0xA BKSP; 0xB CLR; 0xC ENTER; 0xD-0xF ignored (no ERR, no timer reset).
//  State (count = number of occupied digits):
//   EMPTY (count 0), EDIT (1..N-1), FULL_ST (N).
//  Digit in EMPTY/EDIT: DIGITS <= {DIGITS[4N-5:0], key}, MASK <= {MASK[N-2:0],1}, count+1.
//   EMPTY->EDIT; ->FULL_ST when count reaches N.
//  Digit in FULL_ST: buffer unchanged, ERR pulse.
//  BKSP: DIGITS <= {4'h0, DIGITS[4N-1:4]}, MASK <= {1'b0, MASK[N-1:1]}, count-1.
//   FULL_ST->EDIT; EDIT->EMPTY at count 0. BKSP in EMPTY: no-op, no ERR.
//  CLR: DIGITS=0, MASK=0, count=0, ->EMPTY, from any state. No ERR.
//  ENTER with count>0: VALUE <= DIGITS with unoccupied positions forced to 0, VALUE_VALID pulse,
//   edit buffer cleared, ->EMPTY. ENTER in EMPTY: ERR pulse, VALUE unchanged.
//  FULL = (state==FULL_ST), registered with state.
//  Timeout: timer counts clocks while state!=EMPTY.
//   Any accepted event (codes 0x0-0xC, including rejected digits) reloads timer to 0 in the same cycle.
//   On timer==TIMEOUT_CYC-1 with no event that cycle: act as CLR; VALUE untouched, no ERR.
//   Timer is held at 0 in EMPTY. An event on the timeout cycle wins; no clear that cycle.
//  Timer width: $clog2(TIMEOUT_CYC+1); no wrap (it is cleared on expiry).
//  N_DIGITS==1: EMPTY<->FULL_ST directly; the EDIT state is unreachable.
//  Asynchronous reset mid-entry discards the buffer and VALUE immediately.
// STRUCTURE
//  Package key_pkg: key code localparams (KEY_BKSP=4'hA, KEY_CLR=4'hB, KEY_ENTER=4'hC) and state encodings
//   (ST_EMPTY, ST_EDIT, ST_FULL). Shared with the keypad decoder and display controller.
//  Sub-module idle_timer (params TIMEOUT_CYC; in CLK, nRST, run, kick; out expire): holds the timeout counter.
//  Edge detect, FSM and shift datapath live in key_entry_buffer.
// TESTING  (N_DIGITS=8, TIMEOUT_CYC=100)
//  Keys 1,2,3 (Value_en held 20 cyc each) -> DIGITS=32'h0000_0123, MASK=8'h07, FULL=0, exactly 3 shifts.
//  Keys 1..8 then 9 -> after 8 keys DIGITS=32'h1234_5678, FULL=1; key 9 -> ERR pulse, DIGITS unchanged.
//  Keys 4,5,BKSP,6,ENTER -> VALUE=32'h0000_0046, VALUE_VALID 1 cycle, MASK=0; ENTER again -> ERR, VALUE kept.
//  Keys 7,8 then idle 100 cyc -> DIGITS=0, MASK=0 on cycle 100; key at cycle 99 instead -> no clear.
//  Keys 9,CLR,0xE,BKSP -> after CLR buffer empty; 0xE and BKSP no-ops, no ERR.
//  nRST low while Value_en high with 3 digits entered -> all outputs 0; releasing nRST with key held -> no event.

Source files
------------

// File: rtl/key_pkg.sv
// key_pkg: shared definitions for the keypad path (decoder, entry buffer,
// display controller).
//   KEY_*     command key codes; 0x0-0x9 are digits, 0xD-0xF are ignored
//   state_t   entry-buffer occupancy state
//   act_t     per-cycle action decoded by the entry buffer
package key_pkg;

  localparam logic [3:0] KEY_BKSP  = 4'hA;
  localparam logic [3:0] KEY_CLR   = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hC;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_EDIT  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_SHIFT,
    ACT_BKSP,
    ACT_CLR,
    ACT_ENTER,
    ACT_REJECT
  } act_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'h9;
  endfunction

endpackage

// File: rtl/idle_timer.sv
// idle_timer: counts idle clocks while the entry buffer holds digits.
//   CLK     system clock
//   nRST    async active-low reset
//   run     count enable (buffer not empty); counter held at 0 otherwise
//   kick    accepted key event this cycle; reloads the counter to 0
//   expire  timeout reached this cycle with no kick
// TIMEOUT_CYC == 0 disables the timeout entirely.
module idle_timer #(
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic CLK,
  input  logic nRST,
  input  logic run,
  input  logic kick,
  output logic expire
);

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      logic w_unused;
      assign w_unused = &{1'b0, CLK, nRST, run, kick};
      assign expire   = 1'b0;
    end else begin : g_on
      localparam int TW = $clog2(TIMEOUT_CYC + 1);
      localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

      logic [TW-1:0] r_timer;
      logic          w_hit;

      assign w_hit  = run & (r_timer == LAST);
      // a key on the timeout cycle wins over the clear
      assign expire = w_hit & ~kick;

      // counter is cleared on expiry, so it never wraps
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)                    r_timer <= '0;
        else if (!run || kick || w_hit) r_timer <= '0;
        else                          r_timer <= r_timer + 1'b1;
      end
    end
  endgenerate

endmodule

// File: rtl/key_entry_buffer.sv
// key_entry_buffer: turns decoded keypad events into an editable digit entry.
//   CLK, nRST     clock, async active-low reset
//   KEY_Value     key code, sampled on the rising edge of Value_en
//   Value_en      key-valid level from the decoder (may be held)
//   DIGITS        live edit buffer, digit 0 = [3:0] = most recent key
//   DIGIT_MASK    1 = position occupied
//   VALUE         last committed entry (BCD)
//   VALUE_VALID   one-cycle pulse when VALUE updates
//   FULL          all positions occupied
//   ERR           one-cycle pulse on a rejected key
module key_entry_buffer
  import key_pkg::*;
#(
  parameter int N_DIGITS    = 8,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [3:0]            KEY_Value,
  input  logic                  Value_en,
  output logic [4*N_DIGITS-1:0] DIGITS,
  output logic [N_DIGITS-1:0]   DIGIT_MASK,
  output logic [4*N_DIGITS-1:0] VALUE,
  output logic                  VALUE_VALID,
  output logic                  FULL,
  output logic                  ERR
);

  localparam int CW = $clog2(N_DIGITS + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(N_DIGITS);

  logic                  r_en_d;
  logic                  w_evt, w_acc, w_run, w_expire;
  state_t                r_state, w_state_nxt;
  act_t                  w_act;
  logic [CW-1:0]         r_count;
  logic [4*N_DIGITS-1:0] r_digits, r_value, w_committed, w_key_ext;
  logic [N_DIGITS-1:0]   r_mask;
  logic                  r_vv, r_err;

  // en_d resets high so a key held through reset produces no event
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_en_d <= 1'b1;
    else       r_en_d <= Value_en;
  end

  assign w_evt = Value_en & ~r_en_d;
  // 0xD-0xF are dropped entirely: no ERR and no timer reload
  assign w_acc = w_evt & (KEY_Value <= KEY_ENTER);
  assign w_run = (r_state != ST_EMPTY);

  idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_idle_timer (
    .CLK    (CLK),
    .nRST   (nRST),
    .run    (w_run),
    .kick   (w_acc),
    .expire (w_expire)
  );

  // state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= ST_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // action decode (FSM outputs into the datapath)
  always_comb begin
    w_act = ACT_NONE;
    if (w_acc) begin
      if (is_digit(KEY_Value)) begin
        w_act = (r_state == ST_FULL) ? ACT_REJECT : ACT_SHIFT;
      end else begin
        case (KEY_Value)
          KEY_BKSP: w_act = (r_state == ST_EMPTY) ? ACT_NONE : ACT_BKSP;
          KEY_CLR:  w_act = ACT_CLR;
          default:  w_act = (r_state == ST_EMPTY) ? ACT_REJECT : ACT_ENTER;
        endcase
      end
    end else if (w_expire) begin
      w_act = ACT_CLR;
    end
  end

  // next state; for N_DIGITS==1 a shift goes straight to FULL and a
  // backspace straight to EMPTY, so EDIT is never entered
  always_comb begin
    w_state_nxt = r_state;
    case (w_act)
      ACT_SHIFT: w_state_nxt = (r_count == CNT_FULL - 1'b1) ? ST_FULL : ST_EDIT;
      ACT_BKSP:  w_state_nxt = (r_count == CW'(1)) ? ST_EMPTY : ST_EDIT;
      ACT_CLR,
      ACT_ENTER: w_state_nxt = ST_EMPTY;
      default:   w_state_nxt = r_state;
    endcase
  end

  // commit only occupied positions
  always_comb begin
    w_committed = '0;
    for (int i = 0; i < N_DIGITS; i++)
      w_committed[4*i +: 4] = r_mask[i] ? r_digits[4*i +: 4] : 4'h0;
  end

  assign w_key_ext = (4*N_DIGITS)'(KEY_Value);

  // shifts rather than slices keep N_DIGITS==1 legal
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_digits <= '0;
      r_mask   <= '0;
      r_count  <= '0;
      r_value  <= '0;
      r_vv     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_vv  <= 1'b0;
      r_err <= 1'b0;
      case (w_act)
        ACT_SHIFT: begin
          r_digits <= (r_digits << 4) | w_key_ext;
          r_mask   <= (r_mask << 1) | N_DIGITS'(1'b1);
          r_count  <= r_count + 1'b1;
        end
        ACT_BKSP: begin
          r_digits <= r_digits >> 4;
          r_mask   <= r_mask >> 1;
          r_count  <= r_count - 1'b1;
        end
        ACT_CLR: begin
          r_digits <= '0;
          r_mask   <= '0;
          r_count  <= '0;
        end
        ACT_ENTER: begin
          r_value  <= w_committed;
          r_vv     <= 1'b1;
          r_digits <= '0;
          r_mask   <= '0;
          r_count  <= '0;
        end
        ACT_REJECT: r_err <= 1'b1;
        default: ;
      endcase
    end
  end

  assign DIGITS      = r_digits;
  assign DIGIT_MASK  = r_mask;
  assign VALUE       = r_value;
  assign VALUE_VALID = r_vv;
  assign FULL        = (r_state == ST_FULL);
  assign ERR         = r_err;

endmodule
